fetch_ctrl: RTL

Fetch sequencer between the program counter / branch-redirect logic and instruction memory (IM). Owns the fetch PC, issues one-outstanding-request reads to IM over a req/gnt/rvalid handshake, buffers the returned word in a one-entry output register for ID, and squashes in-flight or buffered fetches when EX signals a taken branch. Replaces free-running PC increment with a stall- and flush-aware sequencer.

---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: IM request/response handshake and the ID output handshake.
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;

  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  modport master (
    output im_req, im_addr, id_valid, id_instr, id_pc,
    input  im_gnt, im_rvalid, im_rdata, id_ready
  );

  modport slave (
    input  im_req, im_addr, id_valid, id_instr, id_pc,
    output im_gnt, im_rvalid, im_rdata, id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, one-outstanding IM reads, one-entry ID output plus skid.
// Define FETCH_CTRL_PERF_EN to add perf_fetch / perf_stall / perf_flush counters.
module fetch_ctrl #(
  localparam int unsigned XLEN     = 32,
  parameter  logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            br_taken,
  input  logic            br_abs,
  input  logic [XLEN-1:0] br_pc,
  input  logic [15:0]     br_rel,
  input  logic [XLEN-1:0] br_abs_addr,
  input  logic [15:0]     br_offset,
  fetch_ctrl_if.master    bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch,
  output logic [XLEN-1:0] perf_stall,
  output logic [XLEN-1:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            drop;
  logic            im_req_q;
  logic            id_valid_q;
  logic [XLEN-1:0] id_instr_q;
  logic [XLEN-1:0] id_pc_q;

  logic [XLEN-1:0] rel_off_c;
  logic [XLEN-1:0] abs_off_c;
  logic [XLEN-1:0] br_sum_c;
  logic [XLEN-1:0] br_target_c;

  // Branch target: relative offset is in words, absolute offset in bytes; result word-aligned.
  always_comb begin
    rel_off_c   = {{(XLEN-18){br_rel[15]}}, br_rel, 2'b00};
    abs_off_c   = {{(XLEN-16){br_offset[15]}}, br_offset};
    br_sum_c    = br_abs ? (br_abs_addr + abs_off_c) : (br_pc + rel_off_c);
    br_target_c = br_sum_c & ~XLEN'(3);
  end

  // Sequencer: a redirect overrides every other event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      drop       <= 1'b0;
      im_req_q   <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else if (br_taken) begin
      fetch_pc   <= br_target_c;
      id_valid_q <= 1'b0;
      // An accepted request still owes us a response that must be thrown away.
      if ((state == S_WAIT && !bus.im_rvalid) || (state == S_REQ && bus.im_gnt)) begin
        state    <= S_WAIT;
        drop     <= 1'b1;
        im_req_q <= 1'b0;
      end else begin
        state    <= halt ? S_IDLE : S_REQ;
        drop     <= 1'b0;
        im_req_q <= !halt;
      end
    end else begin
      if (id_valid_q && bus.id_ready) begin
        id_valid_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (!halt) begin
            state    <= S_REQ;
            im_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.im_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= S_WAIT;
            im_req_q <= 1'b0;
          end else if (halt) begin
            state    <= S_IDLE;
            im_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.im_rvalid) begin
            if (drop) begin
              drop     <= 1'b0;
              state    <= halt ? S_IDLE : S_REQ;
              im_req_q <= !halt;
            end else if (!id_valid_q || bus.id_ready) begin
              id_valid_q <= 1'b1;
              id_instr_q <= bus.im_rdata;
              id_pc_q    <= req_pc;
              state      <= halt ? S_IDLE : S_REQ;
              im_req_q   <= !halt;
            end else begin
              skid_instr <= bus.im_rdata;
              skid_pc    <= req_pc;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.id_ready) begin
            id_valid_q <= 1'b1;
            id_instr_q <= skid_instr;
            id_pc_q    <= skid_pc;
            state      <= halt ? S_IDLE : S_REQ;
            im_req_q   <= !halt;
          end
        end
        default: begin
          state    <= S_IDLE;
          im_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.im_req   = im_req_q;
  assign bus.im_addr  = fetch_pc;
  assign bus.id_valid = id_valid_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;

`ifdef FETCH_CTRL_PERF_EN
  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (id_valid_q && bus.id_ready) begin
        perf_fetch <= perf_fetch + XLEN'(1);
      end
      if (state == S_HOLD) begin
        perf_stall <= perf_stall + XLEN'(1);
      end
      if (br_taken) begin
        perf_flush <= perf_flush + XLEN'(1);
      end
    end
  end
`endif

endmodule
